// File: rtl/sat_pkg.sv
// Shared types and saturation bounds for the saturating frame accumulator.
package sat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Largest positive two's-complement value of width w, zero-extended to 64 bits.
  function automatic logic [63:0] SAT_MAX(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of width w; only the low w bits are meaningful.
  function automatic logic [63:0] SAT_MIN(input int w);
    return ~SAT_MAX(w);
  endfunction

endpackage

// File: rtl/sat_addsub.sv
// Combinational N-bit signed add/subtract with clamping to the representable range.
module sat_addsub
  import sat_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] acc_i,
  input  logic [N-1:0] a_i,
  input  logic         sub_i,
  output logic [N-1:0] res_o,
  output logic         ovf_o
);

  localparam logic [N-1:0] MAX_C = N'(SAT_MAX(N));
  localparam logic [N-1:0] MIN_C = N'(SAT_MIN(N));

  logic [N:0] acc_x_s;
  logic [N:0] a_x_s;
  logic [N:0] sum_s;

  assign acc_x_s = {acc_i[N-1], acc_i};
  assign a_x_s   = {a_i[N-1], a_i};

  // Exact N+1-bit result; the two top bits disagree exactly when it leaves the N-bit range.
  always_comb begin
    sum_s = {(N+1){1'b0}};
    res_o = {N{1'b0}};
    ovf_o = 1'b0;
    if (sub_i) begin
      sum_s = acc_x_s - a_x_s;
    end else begin
      sum_s = acc_x_s + a_x_s;
    end
    case (sum_s[N:N-1])
      2'b01: begin
        res_o = MAX_C;
        ovf_o = 1'b1;
      end
      2'b10: begin
        res_o = MIN_C;
        ovf_o = 1'b1;
      end
      default: begin
        res_o = sum_s[N-1:0];
        ovf_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sat_accumulator.sv
// Frame accumulator: sums TAPS signed samples with per-step saturation and
// presents the result with a valid/ready handshake.
module sat_accumulator
  import sat_pkg::*;
#(
  parameter int N    = 4,
  parameter int TAPS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         sat_flag
);

  localparam int            CW     = $clog2(TAPS) + 1;
  localparam logic [CW-1:0] LAST_C = CW'(TAPS - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_q, sat_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic          accept_s;
  logic          last_s;
  logic [N-1:0]  operand_s;
  logic [N-1:0]  step_res_s;
  logic          step_ovf_s;

  assign accept_s  = in_valid & in_ready_q;
  assign last_s    = (cnt_q == LAST_C);
  // A new frame starts from zero, not from the previous frame's result.
  assign operand_s = (state_q == ST_IDLE) ? {N{1'b0}} : acc_q;

  sat_addsub #(.N(N)) u_addsub (
    .acc_i (operand_s),
    .a_i   (A),
    .sub_i (sub),
    .res_o (step_res_s),
    .ovf_o (step_ovf_s)
  );

  // Next-state logic for FSM, tap counter, accumulator and sticky flag.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          acc_d = step_res_s;
          sat_d = step_ovf_s;
          if (last_s) begin
            state_d = ST_DONE;
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = ST_ACCUM;
            cnt_d   = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          acc_d = step_res_s;
          sat_d = sat_q | step_ovf_s;
          if (last_s) begin
            state_d = ST_DONE;
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = ST_ACCUM;
            cnt_d   = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = {N{1'b0}};
        cnt_d   = {CW{1'b0}};
        sat_d   = 1'b0;
      end
    endcase
    in_ready_d  = (state_d != ST_DONE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= {N{1'b0}};
      cnt_q       <= {CW{1'b0}};
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign S         = acc_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_sat_accumulator.sv
// Bench for sat_accumulator: a TAPS=4 and a TAPS=1 instance against a frame-level model.
module tb_sat_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv   [2];
  logic [3:0] a_in [2];
  logic       sb   [2];
  logic       ordy [2];
  logic       ir   [2];
  logic       ov   [2];
  logic [3:0] s_out[2];
  logic       sf   [2];

  int n_checks = 0;
  int n_fail   = 0;

  int m_n[2];
  int m_acc[2];
  bit m_done[2];
  bit m_sat[2];
  int taps[2] = '{4, 1};

  always #5 clk = ~clk;

  sat_accumulator #(.N(4), .TAPS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .A(a_in[0]),
    .sub(sb[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .S(s_out[0]), .sat_flag(sf[0]));

  sat_accumulator #(.N(4), .TAPS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .A(a_in[1]),
    .sub(sb[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .S(s_out[1]), .sat_flag(sf[1]));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [3:0] v);
    return int'($signed(v));
  endfunction

  // Reference model: one frame of TAPS samples, each step clamped to [-8, 7].
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_n[k] = 0; m_acc[k] = 0; m_done[k] = 1'b0; m_sat[k] = 1'b0;
      end else if (m_done[k]) begin
        if (ordy[k] === 1'b1) m_done[k] = 1'b0;
      end else if (iv[k] === 1'b1) begin
        int base, v;
        bit clamped;
        base = (m_n[k] == 0) ? 0 : m_acc[k];
        v = sb[k] ? base - sx(a_in[k]) : base + sx(a_in[k]);
        clamped = (v > 7) || (v < -8);
        if (v > 7) v = 7;
        if (v < -8) v = -8;
        m_acc[k] = v;
        m_sat[k] = ((m_n[k] == 0) ? 1'b0 : m_sat[k]) | clamped;
        m_n[k]++;
        if (m_n[k] == taps[k]) begin
          m_done[k] = 1'b1;
          m_n[k] = 0;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("cmp_out_valid[%0d]", k), int'(ov[k]), int'(m_done[k]));
      chk($sformatf("cmp_in_ready[%0d]", k), int'(ir[k]), int'(!m_done[k]));
      if (m_done[k]) begin
        chk($sformatf("cmp_S[%0d]", k), sx(s_out[k]), m_acc[k]);
        chk($sformatf("cmp_sat_flag[%0d]", k), int'(sf[k]), int'(m_sat[k]));
      end
    end
  end

  task automatic send(input int k, input int a, input bit s);
    @(negedge clk);
    iv[k] = 1'b1;
    a_in[k] = 4'(a);
    sb[k] = s;
  endtask

  // Called right after the last send: the next negedge is the cycle after the final accept.
  task automatic expect_frame(input int k, input string name, input int exp_s, input int exp_f);
    @(negedge clk);
    iv[k] = 1'b0;
    chk({name, "_valid"}, int'(ov[k]), 1);
    chk({name, "_S"}, sx(s_out[k]), exp_s);
    chk({name, "_sat"}, int'(sf[k]), exp_f);
  endtask

  task automatic check_reset_outputs(input int k, input string name);
    chk({name, "_S"}, int'(s_out[k]), 0);
    chk({name, "_sat"}, int'(sf[k]), 0);
    chk({name, "_valid"}, int'(ov[k]), 0);
    chk({name, "_ready"}, int'(ir[k]), 1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; a_in[k] = 4'd0; sb[k] = 1'b0; ordy[k] = 1'b1;
    end
    #12;
    check_reset_outputs(0, "reset4");
    check_reset_outputs(1, "reset1");
    @(negedge clk); #2 rst_n = 1'b1;

    // 1+2+3+1 = 7, no saturation, valid for exactly one cycle
    send(0, 1, 1'b0); send(0, 2, 1'b0); send(0, 3, 1'b0); send(0, 1, 1'b0);
    expect_frame(0, "add_basic", 7, 0);
    @(negedge clk);
    chk("add_basic_one_cycle", int'(ov[0]), 0);

    // 5, 10->7 (sat), 4, 4
    send(0, 5, 1'b0); send(0, 5, 1'b0); send(0, -3, 1'b0); send(0, 0, 1'b0);
    expect_frame(0, "pos_sat", 4, 1);

    // -5, -10->-8, -9->-8, -8
    send(0, -5, 1'b0); send(0, -5, 1'b0); send(0, 1, 1'b1); send(0, 0, 1'b0);
    expect_frame(0, "neg_sat", -8, 1);

    // TAPS=1: 0 - (-8) clamps to +7; next frame restarts from zero with a clear flag
    send(1, -8, 1'b1);
    expect_frame(1, "taps1_sub_min", 7, 1);
    send(1, 2, 1'b0);
    expect_frame(1, "taps1_next", 2, 0);

    // Back-pressure: result held for three cycles, extra input ignored
    ordy[0] = 1'b0;
    send(0, 1, 1'b0); send(0, 1, 1'b0); send(0, 1, 1'b0); send(0, 1, 1'b0);
    expect_frame(0, "bp_first", 4, 0);
    for (int c = 0; c < 3; c++) begin
      iv[0] = 1'b1; a_in[0] = 4'd7; sb[0] = 1'b0;
      @(negedge clk);
      chk("bp_hold_valid", int'(ov[0]), 1);
      chk("bp_hold_ready", int'(ir[0]), 0);
      chk("bp_hold_S", sx(s_out[0]), 4);
      chk("bp_hold_sat", int'(sf[0]), 0);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    chk("bp_release_valid", int'(ov[0]), 0);
    chk("bp_release_ready", int'(ir[0]), 1);

    // Reset mid-frame discards the partial frame
    send(0, 3, 1'b0); send(0, 3, 1'b0);
    @(negedge clk);
    iv[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(0, "midreset");
    @(negedge clk); #2 rst_n = 1'b1;
    send(0, 1, 1'b0); send(0, 1, 1'b0); send(0, 1, 1'b0); send(0, 1, 1'b0);
    expect_frame(0, "after_reset", 4, 0);

    // Randomised traffic on both instances, checked every cycle against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom_range(0, 9) < 7);
        a_in[k] = 4'($urandom_range(0, 15));
        sb[k]   = 1'($urandom_range(0, 1));
        ordy[k] = ($urandom_range(0, 9) < 6);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1;
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sat_accumulator.md
SAT_ACCUMULATOR -- requirements
Module: sat_accumulator

Interface
REQ-001 Parameter N, default 4: signed two's-complement data width; SHALL be >= 2.
REQ-002 Parameter TAPS, default 4: samples accumulated per frame; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  sample A and mode sub are valid this cycle.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 A  input  N  signed sample.
REQ-008 sub  input  1  0: acc + A; 1: acc - A. Sampled with A.
REQ-009 out_valid  output  1  frame result S is valid.
REQ-010 out_ready  input  1  consumer accepts S.
REQ-011 S  output  N  signed saturated frame result.
REQ-012 sat_flag  output  1  at least one saturation occurred in the frame, valid with out_valid.

Function
REQ-013 Accept: a sample SHALL be taken only on a cycle where in_valid and in_ready are both high.
REQ-014 States: IDLE, ACCUM, DONE. IDLE -> ACCUM on first accept when TAPS > 1. IDLE or ACCUM -> DONE on the accept that completes TAPS samples. DONE -> IDLE when out_ready is high. Otherwise hold.
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DONE.
REQ-016 out_valid SHALL be 1 exactly in DONE. S and sat_flag SHALL hold stable while out_valid is high and out_ready is low.
REQ-017 First accept of a frame: the operand SHALL be 0, not the previous accumulator value.
REQ-018 Each step SHALL compute acc ± A at N+1 bits from sign-extended operands.
REQ-019 Each step's result SHALL be clamped to the range [-2^(N-1), 2^(N-1)-1].
REQ-020 Overflow SHALL saturate in both directions: positive to {0,1...1}, negative to {1,0...0}. This includes 0 - (-2^(N-1)) -> +max.
REQ-021 Saturation SHALL apply per step, not once at frame end. A later step SHALL resume from the clamped value.
REQ-022 sat_flag SHALL be sticky within a frame and cleared at the first accept of the next frame.
REQ-023 Latency: out_valid SHALL rise on the cycle after the final accept. S SHALL equal the registered accumulator.
REQ-024 Tap counter: width $clog2(TAPS)+1, reset at frame completion. There SHALL be no wrap-around beyond TAPS.
REQ-025 TAPS = 1: each accept SHALL go IDLE -> DONE directly, with S = sat(0 ± A).
REQ-026 Gaps with in_valid low in ACCUM SHALL not alter acc, counter or state.

Reset
REQ-027 On rst_n low, at any time including mid-frame: state = IDLE, acc = 0, counter = 0, S = 0, sat_flag = 0, out_valid = 0, in_ready = 1.
REQ-028 Partial frames SHALL be discarded by reset, and no output SHALL be produced for them.
REQ-029 Deassertion of rst_n needs no synchronisation inside this block.

Structure
REQ-030 Package sat_pkg SHALL hold the state enum type.
REQ-031 sat_pkg SHALL also hold parametrised SAT_MAX/SAT_MIN constant functions of width.
REQ-032 The sub-module sat_addsub #(N) SHALL be combinational. Inputs: acc, A, sub. Outputs: clamped N-bit result and overflow bit. It SHALL be instantiated once.
REQ-033 The top level SHALL contain only the FSM, tap counter, accumulator and output registers.

Verification (N=4, TAPS=4 unless stated)
REQ-034 Add 1,2,3,1, out_ready=1 -> S=7, sat_flag=0, out_valid for 1 cycle.
REQ-035 Add 5,5,-3,0 -> step values 5, 7 (sat), 4, 4 -> S=4, sat_flag=1.
REQ-036 Add -5,-5, then sub 1, add 0 -> -8 (sat), -8 (sat) -> S=-8, sat_flag=1.
REQ-037 TAPS=1, sub with A=-8 -> S=+7, sat_flag=1. In the following frame, add 2 -> S=2, sat_flag=0.
REQ-038 Back-pressure: hold out_ready=0 for 3 cycles in DONE -> S and sat_flag stable, in_ready=0, extra in_valid ignored. Then out_ready=1 -> IDLE.
REQ-039 After 2 accepts, pull rst_n low -> all outputs 0 immediately. A fresh 4-sample frame of 1s -> S=4.
